// File: rtl/lpf_stage_scheduler.sv
// -----------------------------------------------------------------------------
// lpf_stage_scheduler
// Controller for the cascaded moving-average low-pass filter in the lock-in
// amplifier path. It accepts a requested stage count over a valid/ready
// handshake and drives a thermometer-coded stage enable mask. It can bring
// stages in one at a time (ramp). It counts filter output samples until the
// chain has settled, and then flags that the output can be trusted.
//
// Optional build macro: LPF_SCHED_FLUSH_EN
//   defined   : flush pulses while a full or first ramp step is applied.
//   undefined : flush is tied low. Longer settle counts wash out stale history.
//               A full apply waits (target+1) blocks. A first ramp step waits
//               two blocks.
// -----------------------------------------------------------------------------
module lpf_stage_scheduler #(
   parameter int avg_pow    = 5,
   parameter int num_stages = 8
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [$clog2(num_stages+1)-1:0]   cfg_stages_i,
   input  logic                              ramp_en_i,
   input  logic                              cfg_valid_i,
   output logic                              cfg_ready_o,
   input  logic                              filt_valid_i,
   output logic [num_stages-1:0]             stage_enable_o,
   output logic                              flush_o,
   output logic                              settled_o,
   output logic                              busy_o,
   output logic [$clog2(num_stages+1)-1:0]   cur_stages_o
);

   localparam int SW    = $clog2(num_stages + 1);
   localparam int cnt_w = $clog2(num_stages) + avg_pow + 1;

   // One stage worth of filter outputs (2^avg_pow).
   localparam logic [cnt_w-1:0] BLK = cnt_w'(1) << avg_pow;

   typedef enum logic [1:0] {
      ST_LOCKED = 2'd0,
      ST_APPLY  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_STEP   = 2'd3
   } state_t;

   // How the accepted request is applied. The choice is made at acceptance,
   // while the settled flag still describes the old configuration.
   typedef enum logic [1:0] {
      MODE_FULL   = 2'd0,
      MODE_RAMP   = 2'd1,
      MODE_SHRINK = 2'd2
   } mode_t;

   state_t              state_q,   state_d;
   mode_t               mode_q,    mode_d;
   logic [SW-1:0]       target_q,  target_d;
   logic [SW-1:0]       cur_q,     cur_d;
   logic [num_stages-1:0] en_q,    en_d;
   logic                flush_q,   flush_d;
   logic                settled_q, settled_d;
   logic                busy_q,    busy_d;
   logic                ready_q,   ready_d;
   logic [cnt_w-1:0]    cnt_q,     cnt_d;

   logic                accept_s;
   logic [SW-1:0]       clamp_s;
   mode_t               mode_s;
   logic                flush_s;

   // Thermometer code: bit i is set when stage i is below the stage count.
   function automatic logic [num_stages-1:0] therm(input logic [SW-1:0] n);
      logic [num_stages-1:0] t;
      t = {num_stages{1'b0}};
      for (int i = 0; i < num_stages; i++) begin
         t[i] = (i < int'(n));
      end
      return t;
   endfunction

   assign accept_s = cfg_valid_i && ready_q;

   // Clamp the request and classify it against the present configuration.
   always_comb begin
      if (cfg_stages_i > SW'(num_stages)) begin
         clamp_s = SW'(num_stages);
      end else begin
         clamp_s = cfg_stages_i;
      end

      if (settled_q && (clamp_s <= cur_q)) begin
         mode_s = MODE_SHRINK;
      end else if (settled_q && ramp_en_i && (clamp_s > cur_q)) begin
         mode_s = MODE_RAMP;
      end else begin
         mode_s = MODE_FULL;
      end

`ifdef LPF_SCHED_FLUSH_EN
      if (mode_s == MODE_FULL) begin
         flush_s = 1'b1;
      end else if ((mode_s == MODE_RAMP) && (cur_q == {SW{1'b0}})) begin
         flush_s = 1'b1;
      end else begin
         flush_s = 1'b0;
      end
`else
      flush_s = 1'b0;
`endif
   end

   // Next-state and next-output logic of the sequencing FSM.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      target_d  = target_q;
      cur_d     = cur_q;
      flush_d   = 1'b0;
      settled_d = settled_q;
      busy_d    = busy_q;
      cnt_d     = cnt_q;

      if (accept_s) begin
         // A new request always restarts from APPLY, even mid-sequence and
         // even when the final settle sample arrives in the same cycle.
         state_d   = ST_APPLY;
         target_d  = clamp_s;
         mode_d    = mode_s;
         flush_d   = flush_s;
         settled_d = 1'b0;
         busy_d    = 1'b1;
      end else begin
         case (state_q)
            ST_LOCKED: begin
               state_d = ST_LOCKED;
            end

            ST_APPLY: begin
               case (mode_q)
                  MODE_RAMP: begin
                     cur_d = cur_q + SW'(1);
`ifdef LPF_SCHED_FLUSH_EN
                     cnt_d = BLK;
`else
                     if (cur_q == {SW{1'b0}}) begin
                        cnt_d = BLK << 1;
                     end else begin
                        cnt_d = BLK;
                     end
`endif
                  end
                  MODE_SHRINK: begin
                     cur_d = target_q;
                     cnt_d = cnt_w'(1);
                  end
                  default: begin
                     cur_d = target_q;
`ifdef LPF_SCHED_FLUSH_EN
                     cnt_d = cnt_w'(target_q) << avg_pow;
`else
                     cnt_d = (cnt_w'(target_q) + cnt_w'(1)) << avg_pow;
`endif
                  end
               endcase

               if (target_q == {SW{1'b0}}) begin
                  state_d   = ST_LOCKED;
                  settled_d = 1'b1;
                  busy_d    = 1'b0;
               end else begin
                  state_d = ST_SETTLE;
               end
            end

            ST_SETTLE: begin
               if (filt_valid_i && (cnt_q != {cnt_w{1'b0}})) begin
                  cnt_d = cnt_q - cnt_w'(1);
                  if (cnt_q == cnt_w'(1)) begin
                     if (cur_q == target_q) begin
                        state_d   = ST_LOCKED;
                        settled_d = 1'b1;
                        busy_d    = 1'b0;
                     end else begin
                        state_d = ST_STEP;
                     end
                  end else begin
                     state_d = ST_SETTLE;
                  end
               end else begin
                  state_d = ST_SETTLE;
               end
            end

            ST_STEP: begin
               cur_d   = cur_q + SW'(1);
               cnt_d   = BLK;
               state_d = ST_SETTLE;
            end

            default: begin
               state_d = ST_LOCKED;
            end
         endcase
      end

      en_d    = therm(cur_d);
      ready_d = (state_d != ST_APPLY);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ST_LOCKED;
         mode_q    <= MODE_FULL;
         target_q  <= {SW{1'b0}};
         cur_q     <= {SW{1'b0}};
         en_q      <= {num_stages{1'b0}};
         flush_q   <= 1'b0;
         settled_q <= 1'b1;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
         cnt_q     <= {cnt_w{1'b0}};
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         target_q  <= target_d;
         cur_q     <= cur_d;
         en_q      <= en_d;
         flush_q   <= flush_d;
         settled_q <= settled_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         cnt_q     <= cnt_d;
      end
   end

   assign cfg_ready_o    = ready_q;
   assign stage_enable_o = en_q;
   assign flush_o        = flush_q;
   assign settled_o      = settled_q;
   assign busy_o         = busy_q;
   assign cur_stages_o   = cur_q;

endmodule

// File: tb/tb_lpf_stage_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for lpf_stage_scheduler (avg_pow=5, num_stages=8).
// Each request is turned into a list of settle segments (stage count, number of
// filter samples). The list is built directly from the scheduling rules. Random
// filt_valid traffic is then driven against that list.
// -----------------------------------------------------------------------------
module tb_lpf_stage_scheduler;

   localparam int AP  = 5;
   localparam int NS  = 8;
   localparam int SW  = 4;
   localparam int BLK = 1 << AP;

`ifdef LPF_SCHED_FLUSH_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [SW-1:0] cfg_stages;
   logic          ramp_en;
   logic          cfg_valid;
   logic          cfg_ready;
   logic          filt_valid;
   logic [NS-1:0] stage_enable;
   logic          flush;
   logic          settled;
   logic          busy;
   logic [SW-1:0] cur_stages;

   always #5 clk = ~clk;

   lpf_stage_scheduler #(.avg_pow(AP), .num_stages(NS)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .cfg_stages_i   (cfg_stages),
      .ramp_en_i      (ramp_en),
      .cfg_valid_i    (cfg_valid),
      .cfg_ready_o    (cfg_ready),
      .filt_valid_i   (filt_valid),
      .stage_enable_o (stage_enable),
      .flush_o        (flush),
      .settled_o      (settled),
      .busy_o         (busy),
      .cur_stages_o   (cur_stages)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: what the scheduler should currently hold.
   int m_cur     = 0;
   bit m_settled = 1'b1;
   int seg_st[$];
   int seg_need[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NS-1:0] therm(input int n);
      logic [31:0] m;
      m = (32'd1 << n) - 32'd1;
      return m[NS-1:0];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cur"},     32'(cur_stages), 0);
      chk({tag, "_en"},      32'(stage_enable), 0);
      chk({tag, "_flush"},   32'(flush), 0);
      chk({tag, "_settled"}, 32'(settled), 1);
      chk({tag, "_busy"},    32'(busy), 0);
      chk({tag, "_ready"},   32'(cfg_ready), 1);
   endtask

   // Issue one request. fv_acc drives filt_valid during the handshake cycle.
   // stop_seg >= 0 abandons the sequence one sample short of finishing that
   // segment, which leaves the DUT mid-settle.
   task automatic run_cfg(input int req, input bit ramp, input bit fv_acc, input int stop_seg);
      int t;
      bit exp_fl;
      int cnt;
      int lim;
      t = (req > NS) ? NS : req;
      seg_st.delete();
      seg_need.delete();
      if (m_settled && (t <= m_cur)) begin
         exp_fl = 1'b0;
         if (t > 0) begin seg_st.push_back(t); seg_need.push_back(1); end
      end else if (m_settled && ramp && (t > m_cur)) begin
         exp_fl = FL && (m_cur == 0);
         for (int st = m_cur + 1; st <= t; st++) begin
            seg_st.push_back(st);
            seg_need.push_back((st == 1 && !FL) ? 2 * BLK : BLK);
         end
      end else begin
         exp_fl = FL;
         if (t > 0) begin
            seg_st.push_back(t);
            seg_need.push_back(FL ? t * BLK : (t + 1) * BLK);
         end
      end

      chk("ready_before_req", 32'(cfg_ready), 1);
      cfg_stages = 4'(req);
      ramp_en    = ramp;
      cfg_valid  = 1'b1;
      filt_valid = fv_acc;
      tick;
      cfg_valid  = 1'b0;
      filt_valid = 1'($urandom_range(0, 1));
      chk("apply_ready",   32'(cfg_ready), 0);
      chk("apply_flush",   32'(flush), 32'(exp_fl));
      chk("apply_busy",    32'(busy), 1);
      chk("apply_settled", 32'(settled), 0);
      tick;
      filt_valid = 1'b0;
      m_settled  = 1'b0;

      if (seg_st.size() == 0) begin
         m_cur     = 0;
         m_settled = 1'b1;
         chk("zero_cur",     32'(cur_stages), 0);
         chk("zero_en",      32'(stage_enable), 0);
         chk("zero_settled", 32'(settled), 1);
         chk("zero_busy",    32'(busy), 0);
         chk("zero_ready",   32'(cfg_ready), 1);
         chk("zero_flush",   32'(flush), 0);
         return;
      end

      for (int s = 0; s < seg_st.size(); s++) begin
         if (s > 0) begin
            chk("step_en_hold", 32'(stage_enable), 32'(therm(seg_st[s-1])));
            chk("step_ready",   32'(cfg_ready), 1);
            filt_valid = 1'($urandom_range(0, 1));
            tick;
            filt_valid = 1'b0;
         end
         m_cur = seg_st[s];
         chk("seg_cur",   32'(cur_stages), 32'(m_cur));
         chk("seg_en",    32'(stage_enable), 32'(therm(m_cur)));
         chk("seg_flush", 32'(flush), 0);
         cnt = 0;
         lim = (s == stop_seg) ? seg_need[s] - 1 : seg_need[s];
         while (cnt < lim) begin
            chk("settle_pending", 32'(settled), 0);
            filt_valid = ($urandom_range(0, 3) != 0);
            if (filt_valid) cnt++;
            tick;
         end
         filt_valid = 1'b0;
         if (s == stop_seg) return;
      end

      m_settled = 1'b1;
      chk("done_settled", 32'(settled), 1);
      chk("done_busy",    32'(busy), 0);
      chk("done_ready",   32'(cfg_ready), 1);
      chk("done_cur",     32'(cur_stages), 32'(t));
      chk("done_en",      32'(stage_enable), 32'(therm(t)));
      // filt_valid while locked must not disturb anything.
      repeat (3) begin
         filt_valid = 1'b1;
         tick;
         chk("locked_settled", 32'(settled), 1);
         chk("locked_en",      32'(stage_enable), 32'(therm(t)));
      end
      filt_valid = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      cfg_stages = 4'd0;
      ramp_en    = 1'b0;
      cfg_valid  = 1'b0;
      filt_valid = 1'b0;

      // Reset holds even with a request present.
      tick;
      cfg_valid  = 1'b1;
      cfg_stages = 4'd5;
      tick;
      tick;
      chk_reset_vals("reset");
      cfg_valid = 1'b0;
      rst_n     = 1'b1;
      tick;

      run_cfg(3, 1'b0, 1'b0, -1);   // full apply
      run_cfg(0, 1'b0, 1'b0, -1);   // shrink to passthrough
      run_cfg(4, 1'b1, 1'b0, -1);   // ramp 1..4
      run_cfg(2, 1'b0, 1'b0, -1);   // shrink, single sample
      run_cfg(12, 1'b0, 1'b0, -1);  // clamped to 8
      run_cfg(0, 1'b0, 1'b0, -1);
      run_cfg(5, 1'b1, 1'b0, 1);    // stop mid-ramp at 2 stages
      run_cfg(0, 1'b0, 1'b1, -1);   // abort to 0 racing the final sample
      run_cfg(6, 1'b1, 1'b0, 0);    // stop mid-settle of the first step
      run_cfg(5, 1'b1, 1'b1, -1);   // unsettled request becomes a full apply
      run_cfg(7, 1'b0, 1'b0, 0);    // leave the DUT mid-settle

      // Reset mid-settle.
      rst_n      = 1'b0;
      filt_valid = 1'b1;
      tick;
      chk_reset_vals("midreset");
      m_cur      = 0;
      m_settled  = 1'b1;
      rst_n      = 1'b1;
      filt_valid = 1'b0;
      tick;
      chk_reset_vals("postreset");

      for (int k = 0; k < 12; k++) begin
         run_cfg(int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 0 : -1);
      end
      run_cfg(1, 1'b0, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
